// File: rtl/mem_stage_access.sv
// MEM-stage access unit: drives a req/ack data-memory port with byte/half lane
// steering and load extension, stalls upstream while busy, registers MEM/WB.
module mem_stage_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CLR,
  input  logic        In,
  input  logic [31:0] IR,
  input  logic [31:0] PC,
  input  logic [31:0] R1,
  input  logic [31:0] R2,
  input  logic [31:0] RD2,
  input  logic [4:0]  WbRegNum,
  input  logic        RegWrite,
  input  logic        LOWrite,
  input  logic        HIWrite,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        UnsignedExt_Mem,
  input  logic        Byte,
  input  logic        Half,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        Stall,
  output logic        Out,
  output logic [31:0] IR_o,
  output logic [31:0] PC_o,
  output logic [31:0] R1_o,
  output logic [31:0] R2_o,
  output logic [31:0] MemData,
  output logic [4:0]  WbRegNum_o,
  output logic        RegWrite_o,
  output logic        LOWrite_o,
  output logic        HIWrite_o,
  output logic        MemtoReg_o,
  output logic        AdErr,
  output logic        BusErr
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        out_q, out_d;
  logic [31:0] ir_q, ir_d, pc_q, pc_d, r1_q, r1_d, r2_q, r2_d, memdata_q, memdata_d;
  logic [4:0]  wb_q, wb_d;
  logic        regw_q, regw_d, low_q, low_d, hiw_q, hiw_d, m2r_q, m2r_d;
  logic        aderr_q, aderr_d, buserr_q, buserr_d;

  logic        is_half, is_word, is_op, mis, mis_op, go;
  logic        done, ack_done, bus_err;
  logic [31:0] byte_sh, half_sh, ld_data;

  // Size decode: Byte wins over Half
  always_comb begin
    is_half = ~Byte & Half;
    is_word = ~Byte & ~Half;
    is_op   = In & (MemtoReg | MemWrite);
    mis     = (is_half & R1[0]) | (is_word & (R1[1:0] != 2'b00));
    mis_op  = is_op & mis;
    go      = is_op & ~mis;
  end

  // Little-endian lane steering shared by loads and stores
  always_comb begin
    dm_addr  = {R1[31:2], 2'b00};
    dm_be    = 4'b1111;
    dm_wdata = RD2;
    if (Byte) begin
      dm_be    = 4'b0001 << R1[1:0];
      dm_wdata = {4{RD2[7:0]}};
    end else if (Half) begin
      dm_be    = R1[1] ? 4'b1100 : 4'b0011;
      dm_wdata = {2{RD2[15:0]}};
    end
  end

  always_comb begin
    byte_sh = dm_rdata >> {R1[1:0], 3'b000};
    half_sh = dm_rdata >> {R1[1], 4'b0000};
    if (Byte) begin
      ld_data = UnsignedExt_Mem ? {24'b0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
    end else if (Half) begin
      ld_data = UnsignedExt_Mem ? {16'b0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
    end else begin
      ld_data = dm_rdata;
    end
  end

  // Request FSM; done marks the cycle whose edge loads MEM/WB from the inputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dm_req   = 1'b0;
    Stall    = 1'b0;
    done     = 1'b0;
    ack_done = 1'b0;
    bus_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          dm_req = 1'b1;
          if (dm_ack) begin
            done     = 1'b1;
            ack_done = 1'b1;
          end else begin
            Stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = CW'(1);
          end
        end else begin
          done = 1'b1;
        end
      end
      S_WAIT: begin
        dm_req = 1'b1;
        if (dm_ack) begin
          done     = 1'b1;
          ack_done = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done    = 1'b1;
          bus_err = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          Stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    dm_we = dm_req & MemWrite;
  end

  // MEM/WB next values: load on completion, bubble (payload held) on stall
  always_comb begin
    out_d     = out_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    memdata_d = memdata_q;
    wb_d      = wb_q;
    regw_d    = regw_q;
    low_d     = low_q;
    hiw_d     = hiw_q;
    m2r_d     = m2r_q;
    aderr_d   = aderr_q;
    buserr_d  = buserr_q;
    if (done) begin
      out_d     = In;
      ir_d      = IR;
      pc_d      = PC;
      r1_d      = R1;
      r2_d      = R2;
      wb_d      = WbRegNum;
      m2r_d     = MemtoReg;
      regw_d    = RegWrite & ~(mis_op | bus_err);
      low_d     = LOWrite & ~(mis_op | bus_err);
      hiw_d     = HIWrite & ~(mis_op | bus_err);
      memdata_d = (ack_done & MemtoReg) ? ld_data : 32'h0;
      aderr_d   = mis_op;
      buserr_d  = bus_err;
    end else begin
      out_d    = 1'b0;
      regw_d   = 1'b0;
      low_d    = 1'b0;
      hiw_d    = 1'b0;
      aderr_d  = 1'b0;
      buserr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      ir_q      <= '0;
      pc_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      memdata_q <= '0;
      wb_q      <= '0;
      regw_q    <= 1'b0;
      low_q     <= 1'b0;
      hiw_q     <= 1'b0;
      m2r_q     <= 1'b0;
      aderr_q   <= 1'b0;
      buserr_q  <= 1'b0;
    end else if (CLR) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      ir_q      <= '0;
      pc_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      memdata_q <= '0;
      wb_q      <= '0;
      regw_q    <= 1'b0;
      low_q     <= 1'b0;
      hiw_q     <= 1'b0;
      m2r_q     <= 1'b0;
      aderr_q   <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      memdata_q <= memdata_d;
      wb_q      <= wb_d;
      regw_q    <= regw_d;
      low_q     <= low_d;
      hiw_q     <= hiw_d;
      m2r_q     <= m2r_d;
      aderr_q   <= aderr_d;
      buserr_q  <= buserr_d;
    end
  end

  assign Out        = out_q;
  assign IR_o       = ir_q;
  assign PC_o       = pc_q;
  assign R1_o       = r1_q;
  assign R2_o       = r2_q;
  assign MemData    = memdata_q;
  assign WbRegNum_o = wb_q;
  assign RegWrite_o = regw_q;
  assign LOWrite_o  = low_q;
  assign HIWrite_o  = hiw_q;
  assign MemtoReg_o = m2r_q;
  assign AdErr      = aderr_q;
  assign BusErr     = buserr_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Scoreboard bench for mem_stage_access: directed ops push expected MEM/WB
// results; a monitor pops and compares whenever Out is asserted.
module tb_mem_stage_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst, CLR, In;
  logic [31:0] IR, PC, R1, R2, RD2;
  logic [4:0]  WbRegNum;
  logic        RegWrite, LOWrite, HIWrite, MemtoReg, MemWrite, UnsignedExt_Mem, Byte, Half;
  logic        dm_req, dm_we, dm_ack, Stall, Out;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic [31:0] IR_o, PC_o, R1_o, R2_o, MemData;
  logic [4:0]  WbRegNum_o;
  logic        RegWrite_o, LOWrite_o, HIWrite_o, MemtoReg_o, AdErr, BusErr;

  mem_stage_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .CLR(CLR), .In(In), .IR(IR), .PC(PC), .R1(R1), .R2(R2),
    .RD2(RD2), .WbRegNum(WbRegNum), .RegWrite(RegWrite), .LOWrite(LOWrite),
    .HIWrite(HIWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .UnsignedExt_Mem(UnsignedExt_Mem), .Byte(Byte), .Half(Half),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .Stall(Stall),
    .Out(Out), .IR_o(IR_o), .PC_o(PC_o), .R1_o(R1_o), .R2_o(R2_o),
    .MemData(MemData), .WbRegNum_o(WbRegNum_o), .RegWrite_o(RegWrite_o),
    .LOWrite_o(LOWrite_o), .HIWrite_o(HIWrite_o), .MemtoReg_o(MemtoReg_o),
    .AdErr(AdErr), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, pc, r1, r2, md;
    logic [4:0]  wb;
    logic        rw, lw, m2r, ae, be;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   tag = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every valid MEM/WB output must match the oldest expectation
  always begin
    @(posedge clk);
    #1;
    if (!rst && Out === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got Out=1 with IR_o=0x%08h expected no output", IR_o);
      end else begin
        e = sb.pop_front();
        chk("out_ir", IR_o, e.ir);
        chk("out_pc", PC_o, e.pc);
        chk("out_r1", R1_o, e.r1);
        chk("out_r2", R2_o, e.r2);
        chk("out_memdata", MemData, e.md);
        chk("out_wb", 32'(WbRegNum_o), 32'(e.wb));
        chk("out_regwrite", 32'(RegWrite_o), 32'(e.rw));
        chk("out_lowrite", 32'(LOWrite_o), 32'(e.lw));
        chk("out_hiwrite", 32'(HIWrite_o), 32'h0);
        chk("out_memtoreg", 32'(MemtoReg_o), 32'(e.m2r));
        chk("out_aderr", 32'(AdErr), 32'(e.ae));
        chk("out_buserr", 32'(BusErr), 32'(e.be));
      end
    end
  end

  task automatic set_op(input logic [31:0] r1, input logic [31:0] rd2, input logic m2r,
                        input logic mw, input logic byt, input logic hlf, input logic uns,
                        input logic rw);
    tag++;
    In = 1'b1;
    IR = 32'h1000_0000 + 32'(tag);
    PC = 32'h0040_0000 + 32'(tag * 4);
    R1 = r1;
    R2 = ~r1;
    RD2 = rd2;
    WbRegNum = 5'(tag);
    RegWrite = rw;
    LOWrite = rw;
    HIWrite = 1'b0;
    MemtoReg = m2r;
    MemWrite = mw;
    Byte = byt;
    Half = hlf;
    UnsignedExt_Mem = uns;
  endtask

  task automatic expect_op(input logic [31:0] md, input logic rw, input logic ae, input logic be);
    exp_t x;
    x.ir = IR; x.pc = PC; x.r1 = R1; x.r2 = R2; x.md = md; x.wb = WbRegNum;
    x.rw = rw; x.lw = rw; x.m2r = MemtoReg; x.ae = ae; x.be = be;
    sb.push_back(x);
  endtask

  // Drive one op from a negedge; ack arrives in cycle ack_dly (-1 = never)
  task automatic run(input string nm, input int ack_dly, input int exp_stall, input logic exp_req,
                     input logic chk_lanes, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                     input logic exp_we);
    int   nst = 0;
    int   c = 0;
    logic st = 1'b1;
    while (st && c < 40) begin
      dm_ack = (c == ack_dly);
      #1;
      if (c == 0) begin
        chk({nm, "_req"}, 32'(dm_req), 32'(exp_req));
        if (chk_lanes) begin
          chk({nm, "_be"}, 32'(dm_be), 32'(exp_be));
          chk({nm, "_wdata"}, dm_wdata, exp_wd);
          chk({nm, "_we"}, 32'(dm_we), 32'(exp_we));
          chk({nm, "_addr"}, dm_addr, {R1[31:2], 2'b00});
        end
      end else begin
        chk({nm, "_bubble"}, 32'(Out), 32'h0);
      end
      st = Stall;
      if (st) nst++;
      @(negedge clk);
      c++;
    end
    dm_ack = 1'b0;
    In = 1'b0;
    chk({nm, "_stall_cycles"}, 32'(nst), 32'(exp_stall));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; CLR = 1'b0; In = 1'b0; IR = '0; PC = '0; R1 = '0; R2 = '0; RD2 = '0;
    WbRegNum = '0; RegWrite = 1'b0; LOWrite = 1'b0; HIWrite = 1'b0; MemtoReg = 1'b0;
    MemWrite = 1'b0; UnsignedExt_Mem = 1'b0; Byte = 1'b0; Half = 1'b0;
    dm_ack = 1'b0; dm_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out", 32'(Out), 32'h0);
    chk("rst_r1", R1_o, 32'h0);
    chk("rst_memdata", MemData, 32'h0);
    chk("rst_req", 32'(dm_req), 32'h0);
    chk("rst_stall", 32'(Stall), 32'h0);
    chk("rst_err", 32'({AdErr, BusErr}), 32'h0);
    @(negedge clk);

    // Word store, zero-wait
    set_op(32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_op(32'h0, 1'b0, 1'b0, 1'b0);
    run("wst", 0, 0, 1'b1, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b1);

    // Signed byte load from lane 3, two wait cycles
    dm_rdata = 32'h80FF1234;
    set_op(32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_op(32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
    run("lbs", 2, 2, 1'b1, 1'b1, 4'b1000, 32'h0, 1'b0);

    set_op(32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_op(32'h00000080, 1'b1, 1'b0, 1'b0);
    run("lbu", 2, 2, 1'b1, 1'b1, 4'b1000, 32'h0, 1'b0);

    // Half store to upper half, one wait cycle
    set_op(32'h102, 32'h0000ABCD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_op(32'h0, 1'b0, 1'b0, 1'b0);
    run("hst", 1, 1, 1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 1'b1);

    // Byte has priority over Half: odd address is legal
    set_op(32'h101, 32'h12345655, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_op(32'h0, 1'b0, 1'b0, 1'b0);
    run("bst", 0, 0, 1'b1, 1'b1, 4'b0010, 32'h55555555, 1'b1);

    // Half loads, signed upper and unsigned-looking lower
    dm_rdata = 32'h80017FFF;
    set_op(32'h102, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_op(32'hFFFF8001, 1'b1, 1'b0, 1'b0);
    run("lhs", 0, 0, 1'b1, 1'b1, 4'b1100, 32'h0, 1'b0);

    set_op(32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_op(32'h00007FFF, 1'b1, 1'b0, 1'b0);
    run("lhl", 0, 0, 1'b1, 1'b1, 4'b0011, 32'h0, 1'b0);

    // Misaligned word load: no request, AdErr, writes killed
    set_op(32'h101, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_op(32'h0, 1'b0, 1'b1, 1'b0);
    run("mis", 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0);

    // No ack: TIMEOUT-1 stall cycles then bus error
    set_op(32'h200, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_op(32'h0, 1'b0, 1'b0, 1'b1);
    run("tmo", -1, int'(TO) - 1, 1'b1, 1'b1, 4'b1111, 32'h0, 1'b0);
    #1;
    chk("tmo_idle_req", 32'(dm_req), 32'h0);
    chk("tmo_idle_stall", 32'(Stall), 32'h0);
    @(negedge clk);

    // Non-memory op passes straight through
    set_op(32'h12345, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_op(32'h0, 1'b1, 1'b0, 1'b0);
    run("alu", 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0);

    // CLR while waiting abandons the request and clears MEM/WB
    set_op(32'h400, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("clr_req_before", 32'(dm_req), 32'h1);
    @(negedge clk);
    CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
    In = 1'b0;
    #1;
    chk("clr_req_after", 32'(dm_req), 32'h0);
    chk("clr_stall_after", 32'(Stall), 32'h0);
    chk("clr_out", 32'(Out), 32'h0);
    chk("clr_r1", R1_o, 32'h0);
    chk("clr_ir", IR_o, 32'h0);
    @(negedge clk);

    dm_rdata = 32'h11223344;
    set_op(32'h300, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_op(32'h11223344, 1'b1, 1'b0, 1'b0);
    run("post_clr", 1, 1, 1'b1, 1'b1, 4'b1111, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
